// File: rtl/lif_tdm_if.sv
// Bundled control, current-input and readout signals between the pin-level logic
// and the time-multiplexed LIF scheduler.
interface lif_tdm_if #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2,
    parameter int WIDTH     = 8
);
    logic                 ena;
    logic                 tick;
    logic [WIDTH-1:0]     ext_current;
    logic [IDX_W-1:0]     rd_idx;
    logic [WIDTH-1:0]     rd_state;
    logic [N_NEURONS-1:0] spikes;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    modport master (
        output ena, tick, ext_current, rd_idx,
        input  rd_state, spikes, busy, done, overrun
    );

    modport slave (
        input  ena, tick, ext_current, rd_idx,
        output rd_state, spikes, busy, done, overrun
    );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// One shared leaky-integrate-and-fire datapath swept over N virtual neurons per tick;
// neuron 0 takes an external current, neuron k takes WEIGHT when neuron k-1 fired.
module lif_tdm_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int IDX_W      = 2,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 128,
    parameter int LEAK_SHIFT = 1,
    parameter int WEIGHT     = 100
) (
    input logic       clk,
    input logic       rst_n,
    lif_tdm_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [WIDTH:0]     THR_EXT  = (WIDTH+1)'(THRESHOLD);
    localparam logic [WIDTH-1:0]   W_CUR    = WIDTH'(WEIGHT);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_NEURONS - 1);

    logic [1:0]           fsm_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WIDTH-1:0]     cur_q;
    logic [WIDTH-1:0]     operand_q;
    logic [WIDTH-1:0]     input_q;
    logic [N_NEURONS-1:0] work_q;
    logic [N_NEURONS-1:0] spikes_q;
    logic                 overrun_q;
    logic [WIDTH-1:0]     state_q [N_NEURONS];

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     v_sat;
    logic                 fire;
    logic [N_NEURONS-1:0] work_next;
    logic [WIDTH-1:0]     read_input;
    logic                 accept;

    assign accept = bus.tick & bus.ena;

    // Worst case is (2^W-1) - leak + (2^W-1), which fits in WIDTH+1 bits without wrap.
    assign sum   = {1'b0, operand_q} - ({1'b0, operand_q} >> LEAK_SHIFT) + {1'b0, input_q};
    assign v_sat = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign fire  = ({1'b0, v_sat} >= THR_EXT);

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        work_next        = work_q;
        work_next[idx_q] = fire;
        read_input       = '0;
        if (idx_q == '0) begin
            read_input = cur_q;
        end else if (work_q[idx_q - 1'b1]) begin
            read_input = W_CUR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            idx_q     <= '0;
            cur_q     <= '0;
            operand_q <= '0;
            input_q   <= '0;
            work_q    <= '0;
            spikes_q  <= '0;
            overrun_q <= 1'b0;
            // NOTE: the neuron state file is small and must read 0 after reset, so it is reset explicitly.
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
            end
        end else begin
            overrun_q <= accept && (fsm_q != S_IDLE);
            case (fsm_q)
                S_IDLE: begin
                    if (accept) begin
                        cur_q  <= bus.ext_current;
                        idx_q  <= '0;
                        work_q <= '0;
                        fsm_q  <= S_READ;
                    end
                end
                S_READ: begin
                    operand_q <= state_q[idx_q];
                    input_q   <= read_input;
                    fsm_q     <= S_UPDATE;
                end
                S_UPDATE: begin
                    work_q         <= work_next;
                    state_q[idx_q] <= fire ? '0 : v_sat;
                    if (idx_q == LAST_IDX) begin
                        spikes_q <= work_next;
                        fsm_q    <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        fsm_q <= S_READ;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.rd_state = '0;
        if (int'(bus.rd_idx) < N_NEURONS) begin
            bus.rd_state = state_q[bus.rd_idx];
        end
    end

    assign bus.spikes  = spikes_q;
    assign bus.busy    = (fsm_q != S_IDLE);
    assign bus.done    = (fsm_q == S_DONE);
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: two instances (threshold 128 and 255),
// expected sweep results queued at tick time and compared when done pulses.
module tb_lif_tdm_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = 8;

    typedef struct packed {
        logic [N-1:0][W-1:0] st;
        logic [N-1:0]        spk;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_tdm_if #(.N_NEURONS(N), .IDX_W(IW), .WIDTH(W)) bus_a ();
    lif_tdm_if #(.N_NEURONS(N), .IDX_W(IW), .WIDTH(W)) bus_b ();

    lif_tdm_scheduler #(
        .N_NEURONS(N), .IDX_W(IW), .WIDTH(W),
        .THRESHOLD(128), .LEAK_SHIFT(1), .WEIGHT(100)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    lif_tdm_scheduler #(
        .N_NEURONS(N), .IDX_W(IW), .WIDTH(W),
        .THRESHOLD(255), .LEAK_SHIFT(1), .WEIGHT(100)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    exp_t sb_q[$];
    int   model_a[N];
    int   model_b[N];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;

    always @(negedge clk) begin
        if (bus_a.done === 1'b1) done_cnt_a++;
        if (bus_b.done === 1'b1) done_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? bus_a.done : bus_b.done;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic get_ovr(input int sel);
        return (sel == 0) ? bus_a.overrun : bus_b.overrun;
    endfunction

    function automatic logic [N-1:0] get_spikes(input int sel);
        return (sel == 0) ? bus_a.spikes : bus_b.spikes;
    endfunction

    task automatic drive(input int sel, input logic tk, input logic en, input int ext);
        if (sel == 0) begin
            bus_a.tick = tk; bus_a.ena = en; bus_a.ext_current = W'(ext);
        end else begin
            bus_b.tick = tk; bus_b.ena = en; bus_b.ext_current = W'(ext);
        end
    endtask

    task automatic read_state(input int sel, input int idx, output logic [W-1:0] v);
        if (sel == 0) bus_a.rd_idx = IW'(idx);
        else          bus_b.rd_idx = IW'(idx);
        #1;
        v = (sel == 0) ? bus_a.rd_state : bus_b.rd_state;
    endtask

    // Reference sweep straight from the neuron equations, on integer arithmetic.
    task automatic model_sweep(input int sel, input int ext, output exp_t e);
        int st[N];
        int thr;
        int in_cur;
        int v;
        logic [N-1:0] spk;
        thr = (sel == 0) ? 128 : 255;
        for (int k = 0; k < N; k++) st[k] = (sel == 0) ? model_a[k] : model_b[k];
        spk = '0;
        for (int k = 0; k < N; k++) begin
            if (k == 0)          in_cur = ext;
            else if (spk[k-1])   in_cur = 100;
            else                 in_cur = 0;
            v = st[k] - st[k] / 2 + in_cur;
            if (v > 255) v = 255;
            if (v >= thr) begin
                spk[k] = 1'b1;
                st[k]  = 0;
            end else begin
                st[k] = v;
            end
        end
        for (int k = 0; k < N; k++) begin
            e.st[k] = W'(st[k]);
            if (sel == 0) model_a[k] = st[k];
            else          model_b[k] = st[k];
        end
        e.spk = spk;
    endtask

    task automatic run_sweep(input int sel, input int ext, input int ovr_at);
        exp_t        e;
        exp_t        got_e;
        int          done_at;
        logic [W-1:0] v;
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, ext);
        model_sweep(sel, ext, e);
        sb_q.push_back(e);
        @(negedge clk);
        drive(sel, 1'b0, 1'b1, (~ext) & 255);
        check("busy_after_accept", 32'(get_busy(sel)), 32'd1);
        done_at = -1;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (ovr_at != 0 && k == ovr_at) begin
                check("overrun_pulse", 32'(get_ovr(sel)), 32'd1);
                drive(sel, 1'b0, 1'b1, 0);
            end
            if (ovr_at != 0 && k == ovr_at + 1)
                check("overrun_clear", 32'(get_ovr(sel)), 32'd0);
            if (ovr_at != 0 && k == ovr_at - 1)
                drive(sel, 1'b1, 1'b1, 255);
            if (get_done(sel) === 1'b1) done_at = k;
        end
        check("done_latency", 32'(done_at), 32'(2 * N));
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            got_e = sb_q.pop_front();
            check("spikes", 32'(get_spikes(sel)), 32'(got_e.spk));
            for (int k = 0; k < N; k++) begin
                read_state(sel, k, v);
                check($sformatf("state%0d", k), 32'(v), 32'(got_e.st[k]));
            end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(get_done(sel)), 32'd0);
        check("idle_after_done", 32'(get_busy(sel)), 32'd0);
    endtask

    initial begin
        int dc;
        logic [W-1:0] v;
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);
        bus_a.rd_idx = '0;
        bus_b.rd_idx = '0;
        for (int k = 0; k < N; k++) begin model_a[k] = 0; model_b[k] = 0; end

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_spikes", 32'(bus_a.spikes), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_overrun", 32'(bus_a.overrun), 32'd0);
        for (int k = 0; k < N; k++) begin
            read_state(0, k, v);
            check($sformatf("rst_state%0d", k), 32'(v), 32'd0);
        end

        // Plain sweep, then a chained spike from neuron 0 into neuron 1.
        run_sweep(0, 100, 0);
        run_sweep(0, 100, 0);
        run_sweep(0, 230, 0);

        // Saturation on the high-threshold instance.
        run_sweep(1, 200, 0);
        run_sweep(1, 255, 0);

        // Overrun: second tick sampled at edge 3 of a running sweep.
        dc = done_cnt_a;
        run_sweep(0, 60, 3);
        repeat (10) @(negedge clk);
        check("single_done_on_overrun", 32'(done_cnt_a - dc), 32'd1);

        // Tick with ena low in IDLE is ignored.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 90);
        repeat (3) begin
            @(negedge clk);
            check("ena0_busy", 32'(bus_a.busy), 32'd0);
            check("ena0_overrun", 32'(bus_a.overrun), 32'd0);
        end
        drive(0, 1'b0, 1'b0, 0);
        read_state(0, 0, v);
        check("ena0_state0", 32'(v), 32'(model_a[0]));

        // Reset in the middle of a sweep.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 100);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        dc = done_cnt_a;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus_a.busy), 32'd0);
        check("midrst_spikes", 32'(bus_a.spikes), 32'd0);
        check("midrst_done", 32'(bus_a.done), 32'd0);
        for (int k = 0; k < N; k++) begin
            read_state(0, k, v);
            check($sformatf("midrst_state%0d", k), 32'(v), 32'd0);
            model_a[k] = 0;
            model_b[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt_a - dc), 32'd0);
        run_sweep(0, 100, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
